// File: rtl/clic_scan_arbiter_pkg.sv
// Shared types and defaults for the CLIC scanning arbiter: candidate record, FSM states,
// and the candidate merge rule used both inside a group and across groups.
package clic_scan_arbiter_pkg;

  // Mirrors the SoC-level CLIC constants.
  localparam int unsigned ClicNumSrc  = 256;
  localparam int unsigned ClicCtlBits = 8;
  localparam int unsigned ClicIdBits  = $clog2(ClicNumSrc);

  typedef struct packed {
    logic                   valid;
    logic [ClicIdBits-1:0]  id;
    logic [ClicCtlBits-1:0] ctl;
  } cand_t;

  typedef enum logic [1:0] {
    StScan,
    StCommit,
    StOffer
  } state_e;

  localparam cand_t CandNone = '0;

  // 'lo' must come from lower source ids; it keeps ties.
  function automatic cand_t cand_pick(cand_t lo, cand_t hi);
    if (hi.valid && (!lo.valid || (hi.ctl > lo.ctl))) begin
      return hi;
    end
    return lo;
  endfunction

endpackage

// File: rtl/clic_group_max.sv
// Combinational max-tree over one scan group; highest ctl wins, lower index wins ties.
module clic_group_max
  import clic_scan_arbiter_pkg::*;
#(
  parameter int unsigned SrcPerCycle = 16,
  parameter int unsigned CtlBits     = ClicCtlBits,
  parameter int unsigned IdBits      = ClicIdBits
) (
  input  logic [SrcPerCycle-1:0]         ip,
  input  logic [SrcPerCycle-1:0]         ie,
  input  logic [SrcPerCycle*CtlBits-1:0] ctl,
  input  logic [CtlBits-1:0]             thresh,
  input  logic [IdBits-1:0]              base_id,
  output cand_t                          winner
);

  // Heap-ordered tree: node n has children 2n and 2n+1, leaves start at SrcPerCycle.
  cand_t node [2*SrcPerCycle];

  always_comb begin
    for (int n = 0; n < 2 * SrcPerCycle; n++) begin
      node[n] = CandNone;
    end
    for (int i = 0; i < SrcPerCycle; i++) begin
      node[SrcPerCycle+i].valid = ip[i] & ie[i] & (ctl[i*CtlBits +: CtlBits] > thresh);
      node[SrcPerCycle+i].id    = base_id + IdBits'(i);
      node[SrcPerCycle+i].ctl   = ctl[i*CtlBits +: CtlBits];
    end
    for (int n = SrcPerCycle - 1; n >= 1; n--) begin
      node[n] = cand_pick(node[2*n], node[2*n+1]);
    end
    winner = node[1];
  end

endmodule

// File: rtl/clic_scan_arbiter.sv
// Sequential-scan CLIC arbiter: sweeps sources a group per cycle, then offers the best
// eligible source to the hart over valid/ready and pulses a clear for edge sources.
module clic_scan_arbiter
  import clic_scan_arbiter_pkg::*;
#(
  parameter int unsigned NumSrc      = ClicNumSrc,
  parameter int unsigned CtlBits     = ClicCtlBits,
  parameter int unsigned SrcPerCycle = 16,
  localparam int unsigned IdBits     = $clog2(NumSrc)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumSrc-1:0]         ip_i,
  input  logic [NumSrc-1:0]         ie_i,
  input  logic [NumSrc-1:0]         edge_i,
  input  logic [NumSrc*CtlBits-1:0] ctl_i,
  input  logic [CtlBits-1:0]        thresh_i,
  output logic                      irq_valid_o,
  input  logic                      irq_ready_i,
  output logic [IdBits-1:0]         irq_id_o,
  output logic [CtlBits-1:0]        irq_ctl_o,
  output logic [NumSrc-1:0]         clr_o
);

  localparam int unsigned NumGrp  = NumSrc / SrcPerCycle;
  localparam int unsigned GrpBits = (NumGrp > 1) ? $clog2(NumGrp) : 1;
  localparam logic [GrpBits-1:0] LastGrp = GrpBits'(NumGrp - 1);

  state_e              state_q, state_d;
  logic [GrpBits-1:0]  grp_q, grp_d;
  cand_t               best_q, best_d;
  logic                valid_q, valid_d;
  logic [IdBits-1:0]   id_q, id_d;
  logic [CtlBits-1:0]  ctl_q, ctl_d;
  logic [NumSrc-1:0]   clr_q, clr_d;

  int unsigned         grp_base;
  cand_t               grp_win;
  logic                offer_elig;

  assign grp_base = 32'(grp_q) * SrcPerCycle;

  clic_group_max #(
    .SrcPerCycle (SrcPerCycle),
    .CtlBits     (CtlBits),
    .IdBits      (IdBits)
  ) u_group_max (
    .ip      (ip_i[grp_base +: SrcPerCycle]),
    .ie      (ie_i[grp_base +: SrcPerCycle]),
    .ctl     (ctl_i[grp_base*CtlBits +: SrcPerCycle*CtlBits]),
    .thresh  (thresh_i),
    .base_id (IdBits'(grp_base)),
    .winner  (grp_win)
  );

  // Offered source re-checked live so that a drop of ip/ie or a threshold raise retracts.
  assign offer_elig = ip_i[id_q] & ie_i[id_q] & (ctl_i[32'(id_q)*CtlBits +: CtlBits] > thresh_i);

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    best_d  = best_q;
    valid_d = valid_q;
    id_d    = id_q;
    ctl_d   = ctl_q;
    clr_d   = '0;
    unique case (state_q)
      StScan: begin
        best_d = cand_pick(best_q, grp_win);
        if (grp_q == LastGrp) begin
          grp_d   = '0;
          state_d = StCommit;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      StCommit: begin
        if (best_q.valid) begin
          id_d    = best_q.id;
          ctl_d   = best_q.ctl;
          valid_d = 1'b1;
          state_d = StOffer;
        end else begin
          best_d  = CandNone;
          grp_d   = '0;
          state_d = StScan;
        end
      end
      StOffer: begin
        // Handshake takes precedence over retraction.
        if (irq_ready_i || !offer_elig) begin
          if (irq_ready_i) begin
            clr_d[id_q] = edge_i[id_q];
          end
          valid_d = 1'b0;
          best_d  = CandNone;
          grp_d   = '0;
          state_d = StScan;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StScan;
      grp_q   <= '0;
      best_q  <= CandNone;
      valid_q <= 1'b0;
      id_q    <= '0;
      ctl_q   <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      best_q  <= best_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ctl_q   <= ctl_d;
      clr_q   <= clr_d;
    end
  end

  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_ctl_o   = ctl_q;
  assign clr_o       = clr_q;

endmodule

// File: tb/tb_clic_scan_arbiter.sv
// Directed bench for clic_scan_arbiter: table of single-sweep scenarios plus hand-written
// handshake, edge-clear, retraction and reset sequences.
module tb_clic_scan_arbiter;

  localparam int NumSrc = 256;
  localparam int CtlBits = 8;
  localparam int Lat = 17;
  localparam int Sweep = 17;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NumSrc-1:0]         ip, ie, edg;
  logic [NumSrc*CtlBits-1:0] ctl;
  logic [CtlBits-1:0]        thresh;
  logic                      ready;
  logic                      valid;
  logic [7:0]                id;
  logic [CtlBits-1:0]        octl;
  logic [NumSrc-1:0]         clr;

  clic_scan_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ip_i        (ip),
    .ie_i        (ie),
    .edge_i      (edg),
    .ctl_i       (ctl),
    .thresh_i    (thresh),
    .irq_valid_o (valid),
    .irq_ready_i (ready),
    .irq_id_o    (id),
    .irq_ctl_o   (octl),
    .clr_o       (clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    int         s0, s1, s2;
    logic [7:0] c0, c1, c2;
    logic [7:0] th;
    logic       ev;
    int         eid;
    logic [7:0] ectl;
  } vec_t;

  vec_t tab [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    ip = '0; ie = '0; edg = '0; ctl = '0; thresh = '0; ready = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [7:0] c, input logic e);
    ip[k] = 1'b1;
    ie[k] = 1'b1;
    ctl[k*CtlBits +: CtlBits] = c;
    edg[k] = e;
  endtask

  // Returns at a negedge with reset released; the next posedge scans group 0.
  task automatic start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  // One-cycle ready pulse from a negedge, returns at the following negedge.
  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  int cyc;
  int bad;

  initial begin
    rst = 1'b1;
    clear_all();
    tab[0] = '{37, -1, -1, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 37, 8'h40};
    tab[1] = '{5, 200, 100, 8'h80, 8'h80, 8'h7F, 8'h00, 1'b1, 5, 8'h80};
    tab[2] = '{12, -1, -1, 8'h10, 8'h00, 8'h00, 8'h10, 1'b0, 0, 8'h00};
    tab[3] = '{12, -1, -1, 8'h10, 8'h00, 8'h00, 8'h0F, 1'b1, 12, 8'h10};
    tab[4] = '{0, 255, -1, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b1, 255, 8'hFF};
    tab[5] = '{16, 17, 15, 8'h20, 8'h20, 8'h20, 8'h00, 1'b1, 15, 8'h20};
    tab[6] = '{7, -1, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h00};
    tab[7] = '{250, 3, 130, 8'h90, 8'h90, 8'hA0, 8'h00, 1'b1, 130, 8'hA0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset valid", 256'(valid), 256'(0));
    chk("reset id", 256'(id), 256'(0));
    chk("reset ctl", 256'(octl), 256'(0));
    chk("reset clr", clr, '0);

    for (int v = 0; v < 8; v++) begin
      clear_all();
      if (tab[v].s0 >= 0) set_src(tab[v].s0, tab[v].c0, 1'b0);
      if (tab[v].s1 >= 0) set_src(tab[v].s1, tab[v].c1, 1'b0);
      if (tab[v].s2 >= 0) set_src(tab[v].s2, tab[v].c2, 1'b0);
      thresh = tab[v].th;
      start();
      if (tab[v].ev) begin
        wait_valid(Lat + 20, cyc);
        chk($sformatf("v%0d latency", v), 256'(cyc), 256'(Lat));
        chk($sformatf("v%0d id", v), 256'(id), 256'(tab[v].eid));
        chk($sformatf("v%0d ctl", v), 256'(octl), 256'(tab[v].ectl));
      end else begin
        wait_valid(3 * Sweep, cyc);
        chk($sformatf("v%0d no offer", v), 256'(cyc), 256'(-1));
      end
    end

    // Single source held stable while ready stays low.
    clear_all();
    set_src(37, 8'h40, 1'b0);
    start();
    wait_valid(Lat + 20, cyc);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!valid || id != 8'd37 || octl != 8'h40 || clr != '0) bad++;
    end
    chk("hold stable", 256'(bad), 256'(0));

    // Priority tie then accept; with 5 cleared, 200 wins over 100.
    clear_all();
    set_src(5, 8'h80, 1'b0);
    set_src(200, 8'h80, 1'b0);
    set_src(100, 8'h7F, 1'b0);
    start();
    wait_valid(Lat + 20, cyc);
    chk("tie first id", 256'(id), 256'(5));
    accept();
    ip[5] = 1'b0;
    chk("tie accepted valid", 256'(valid), 256'(0));
    wait_valid(Lat + 20, cyc);
    chk("tie second latency", 256'(cyc), 256'(Lat));
    chk("tie second id", 256'(id), 256'(200));

    // Threshold lowered mid-run.
    clear_all();
    set_src(12, 8'h10, 1'b0);
    thresh = 8'h10;
    start();
    wait_valid(3 * Sweep, cyc);
    chk("thresh blocked", 256'(cyc), 256'(-1));
    thresh = 8'h0F;
    wait_valid(2 * Sweep + 2, cyc);
    chk("thresh lowered id", 256'(valid ? id : 8'hEE), 256'(12));

    // Edge clear pulse: exactly one cycle, only bit 9.
    clear_all();
    set_src(9, 8'h20, 1'b1);
    start();
    wait_valid(Lat + 20, cyc);
    accept();
    chk("edge clr pulse", clr, 256'(1) << 9);
    @(negedge clk);
    chk("edge clr gone", clr, '0);
    edg[9] = 1'b0;
    wait_valid(Lat + 20, cyc);
    chk("level reoffer id", 256'(id), 256'(9));
    accept();
    chk("level no clr", clr, '0);

    // Retraction without ready, then retraction racing a handshake.
    clear_all();
    set_src(3, 8'h20, 1'b1);
    start();
    wait_valid(Lat + 20, cyc);
    ie[3] = 1'b0;
    @(negedge clk);
    chk("retract valid", 256'(valid), 256'(0));
    chk("retract clr", clr, '0);
    ie[3] = 1'b1;
    wait_valid(Lat + 20, cyc);
    chk("retract reoffer id", 256'(id), 256'(3));
    ie[3] = 1'b0;
    accept();
    chk("race valid", 256'(valid), 256'(0));
    chk("race clr", clr, 256'(1) << 3);

    // Reset mid-offer, then a fresh sweep re-offers.
    clear_all();
    set_src(37, 8'h40, 1'b1);
    start();
    wait_valid(Lat + 20, cyc);
    rst = 1'b1;
    @(negedge clk);
    chk("rst offer valid", 256'(valid), 256'(0));
    chk("rst offer id", 256'(id), 256'(0));
    chk("rst offer ctl", 256'(octl), 256'(0));
    chk("rst offer clr", clr, '0);
    rst = 1'b0;
    wait_valid(Lat + 20, cyc);
    chk("rst reoffer latency", 256'(cyc), 256'(Lat));
    chk("rst reoffer id", 256'(id), 256'(37));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
